// File: rtl/gm64_pkg.sv
// Shared FSM state type and bus widths for the gm64 memory-port arbiter.
package gm64_pkg;
  localparam int BANK_W = 6;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int GID_W  = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from last_grant+1 (mode=1)
// or fixed priority with the lowest index winning (mode=0); one-hot result.
module rr_pick
  import gm64_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GID_W-1:0]     last_grant,
  input  logic                 mode,
  output logic [NUM_PORTS-1:0] grant
);
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (mode) begin
      // Scan distances 1..NUM_PORTS from the previous winner, wrapping.
      for (int off = 1; off <= NUM_PORTS; off++) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (!found && req[i] && (i == (int'(last_grant) + off) % NUM_PORTS)) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter: picks one requesting channel, issues its access to the
// memory controller and returns completion, read data and timeout status.
module mem_port_arbiter
  import gm64_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        p_req,
  input  logic [NUM_PORTS-1:0]        p_write,
  input  logic [BANK_W*NUM_PORTS-1:0] p_bank,
  input  logic [ADDR_W*NUM_PORTS-1:0] p_addr,
  input  logic [DATA_W*NUM_PORTS-1:0] p_wdata,
  output logic [NUM_PORTS-1:0]        p_ack,
  output logic                        p_err,
  output logic [DATA_W-1:0]           p_rdata,
  output logic                        mc_ce,
  output logic                        mc_write,
  output logic [BANK_W-1:0]           mc_bank,
  output logic [ADDR_W-1:0]           mc_addr,
  output logic [DATA_W-1:0]           mc_wdata,
  input  logic                        mc_busy,
  input  logic                        mc_data_ready,
  input  logic [DATA_W-1:0]           mc_rdata,
  output logic [GID_W-1:0]            grant_id
);
  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [GID_W-1:0] LAST_RST  = GID_W'(NUM_PORTS - 1);

  state_t                 state_q, state_d;
  logic [GID_W-1:0]       grant_id_q, grant_id_d;
  logic [GID_W-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   mc_ce_q, mc_ce_d;
  logic                   mc_write_q, mc_write_d;
  logic [BANK_W-1:0]      mc_bank_q, mc_bank_d;
  logic [ADDR_W-1:0]      mc_addr_q, mc_addr_d;
  logic [DATA_W-1:0]      mc_wdata_q, mc_wdata_d;
  logic [NUM_PORTS-1:0]   p_ack_q, p_ack_d;
  logic                   p_err_q, p_err_d;
  logic [DATA_W-1:0]      p_rdata_q, p_rdata_d;

  logic [NUM_PORTS-1:0]   pick;
  logic [GID_W-1:0]       pick_id;
  logic                   pick_write;
  logic [BANK_W-1:0]      pick_bank;
  logic [ADDR_W-1:0]      pick_addr;
  logic [DATA_W-1:0]      pick_wdata;
  logic                   finish;
  logic                   fin_err;
  logic [DATA_W-1:0]      fin_data;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req       (p_req),
    .last_grant(last_grant_q),
    .mode      (ROUND_ROBIN != 0),
    .grant     (pick)
  );

  always_comb begin
    pick_id    = '0;
    pick_write = 1'b0;
    pick_bank  = '0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick[i]) begin
        pick_id    = GID_W'(i);
        pick_write = p_write[i];
        pick_bank  = p_bank[i*BANK_W +: BANK_W];
        pick_addr  = p_addr[i*ADDR_W +: ADDR_W];
        pick_wdata = p_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    mc_ce_d      = 1'b0;
    mc_write_d   = mc_write_q;
    mc_bank_d    = mc_bank_q;
    mc_addr_d    = mc_addr_q;
    mc_wdata_d   = mc_wdata_q;
    p_ack_d      = '0;
    p_err_d      = 1'b0;
    p_rdata_d    = '0;
    finish       = 1'b0;
    fin_err      = 1'b0;
    fin_data     = '0;

    case (state_q)
      IDLE: begin
        if (|p_req) begin
          grant_id_d = pick_id;
          mc_write_d = pick_write;
          mc_bank_d  = pick_bank;
          mc_addr_d  = pick_addr;
          mc_wdata_d = pick_wdata;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!mc_busy) begin
          mc_ce_d    = 1'b1;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
        // The first WAIT cycle overlaps the issue strobe, so a write's busy is not trusted yet.
        if (!mc_write_q && mc_data_ready) begin
          finish   = 1'b1;
          fin_data = mc_rdata;
        end else if (mc_write_q && (wait_cnt_q != '0) && !mc_busy) begin
          finish = 1'b1;
        end else if (wait_cnt_q >= CNT_LIMIT) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end
      end
      DONE: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d   = DONE;
      p_err_d   = fin_err;
      p_rdata_d = fin_data;
      for (int i = 0; i < NUM_PORTS; i++) p_ack_d[i] = (grant_id_q == GID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= LAST_RST;
      wait_cnt_q   <= '0;
      mc_ce_q      <= 1'b0;
      mc_write_q   <= 1'b0;
      mc_bank_q    <= '0;
      mc_addr_q    <= '0;
      mc_wdata_q   <= '0;
      p_ack_q      <= '0;
      p_err_q      <= 1'b0;
      p_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      mc_ce_q      <= mc_ce_d;
      mc_write_q   <= mc_write_d;
      mc_bank_q    <= mc_bank_d;
      mc_addr_q    <= mc_addr_d;
      mc_wdata_q   <= mc_wdata_d;
      p_ack_q      <= p_ack_d;
      p_err_q      <= p_err_d;
      p_rdata_q    <= p_rdata_d;
    end
  end

  assign mc_ce    = mc_ce_q;
  assign mc_write = mc_write_q;
  assign mc_bank  = mc_bank_q;
  assign mc_addr  = mc_addr_q;
  assign mc_wdata = mc_wdata_q;
  assign p_ack    = p_ack_q;
  assign p_err    = p_err_q;
  assign p_rdata  = p_rdata_q;
  assign grant_id = grant_id_q;
endmodule
